// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: access width codes, load code, LSU states, bus payloads.
package mips_mem_pkg;

  localparam logic [1:0] SZ_WORD       = 2'b00;
  localparam logic [1:0] SZ_HALF       = 2'b01;
  localparam logic [1:0] SZ_BYTE       = 2'b10;
  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} lsu_state_e;

  // Data-memory request payload as presented on the bus.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dreq_t;

  // What the load extractor needs to remember about an outstanding access.
  typedef struct packed {
    logic [1:0] size;
    logic [1:0] off;
    logic       lbu;
    logic       lhu;
  } ld_ctx_t;

  // Reserved width code 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / replicated data and load extract / extend.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  input  logic        lbu,
  input  logic        lhu,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Little-endian lane selection; anything not byte/half is treated as a word.
  always_comb begin
    be    = 4'b1111;
    wdata = wd;
    ldata = rdata;
    rbyte = rdata[{off, 3'b000} +: 8];
    rhalf = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{wd[7:0]}};
        ldata = lbu ? {24'h000000, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        be    = 4'b0011 << off;
        wdata = {2{wd[15:0]}};
        ldata = lhu ? {16'h0000, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data bus, stalls the pipeline, returns load data.
module mem_stage_lsu
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWriteM,
  input  logic [1:0]  MemtoRegM,
  input  logic [1:0]  Sh_bM,
  input  logic        lbuM,
  input  logic        lhuM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        ErrorFlush,
  output logic        dreq_valid,
  input  logic        dreq_ready,
  output logic        dreq_we,
  output logic [31:0] dreq_addr,
  output logic [3:0]  dreq_be,
  output logic [31:0] dreq_wdata,
  input  logic        dresp_valid,
  input  logic [31:0] dresp_rdata,
  output logic        mem_stall,
  output logic [31:0] load_dataM,
  output logic        misalign_exc,
  output logic        bus_err_exc
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  lsu_state_e       state, state_nx;
  logic [CNT_W-1:0] tmo_cnt;
  logic             access, misaligned, aligned_acc, tmo_hit, ld_en;
  dreq_t            req_live, req_q, req_c;
  ld_ctx_t          ctx_live, ctx_q, ctx_sel;
  logic [3:0]       be_live;
  logic [31:0]      wdata_live, ldata;

  // Reset also masks the live access so every output reads 0 while rst_n is low.
  assign access      = rst_n & (MemWriteM | (MemtoRegM == MEMTOREG_LOAD)) & ~ErrorFlush;
  assign misaligned  = is_misaligned(Sh_bM, aluoutM[1:0]);
  assign aligned_acc = access & ~misaligned;
  assign tmo_hit     = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // In IDLE the steering follows the live M-stage fields; afterwards it follows the captured access.
  assign ctx_live = '{size: Sh_bM, off: aluoutM[1:0], lbu: lbuM, lhu: lhuM};
  assign ctx_sel  = (state == IDLE) ? ctx_live : ctx_q;

  lsu_lane_align u_align (
    .size  (ctx_sel.size),
    .off   (ctx_sel.off),
    .wd    (writedataM),
    .rdata (dresp_rdata),
    .lbu   (ctx_sel.lbu),
    .lhu   (ctx_sel.lhu),
    .be    (be_live),
    .wdata (wdata_live),
    .ldata (ldata)
  );

  assign req_live = '{we: MemWriteM, addr: {aluoutM[31:2], 2'b00}, be: be_live, wdata: wdata_live};

  assign dreq_we    = req_c.we;
  assign dreq_addr  = req_c.addr;
  assign dreq_be    = req_c.be;
  assign dreq_wdata = req_c.wdata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Timeout counter, request/context capture and load result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt    <= '0;
      req_q      <= '0;
      ctx_q      <= '0;
      load_dataM <= '0;
    end else begin
      if ((state_nx != state) && ((state_nx == REQ) || (state_nx == WAIT))) tmo_cnt <= '0;
      else if ((state == REQ) || (state == WAIT))                         tmo_cnt <= tmo_cnt + CNT_W'(1);
      if ((state == IDLE) && aligned_acc) begin
        req_q <= req_live;
        ctx_q <= ctx_live;
      end
      if (ld_en) load_dataM <= ldata;
    end
  end

  // Next-state and bus/pipeline control.
  always_comb begin
    state_nx     = state;
    req_c        = '0;
    dreq_valid   = 1'b0;
    mem_stall    = 1'b0;
    misalign_exc = 1'b0;
    bus_err_exc  = 1'b0;
    ld_en        = 1'b0;
    case (state)
      IDLE: begin
        misalign_exc = access & misaligned;
        if (aligned_acc) begin
          dreq_valid = 1'b1;
          mem_stall  = 1'b1;
          req_c      = req_live;
          if (dreq_ready) state_nx = MemWriteM ? DONE : WAIT;
          else            state_nx = REQ;
        end
      end
      REQ: begin
        if (ErrorFlush) begin
          state_nx = IDLE;
        end else begin
          dreq_valid = 1'b1;
          mem_stall  = aligned_acc;
          req_c      = req_q;
          if (dreq_ready) begin
            state_nx = req_q.we ? DONE : WAIT;
          end else if (tmo_hit) begin
            bus_err_exc = 1'b1;
            state_nx    = IDLE;
          end
        end
      end
      WAIT: begin
        mem_stall = aligned_acc;
        // A response arriving with the flush is consumed now, so nothing is left to drain.
        if (ErrorFlush) begin
          state_nx = dresp_valid ? IDLE : DRAIN;
        end else if (dresp_valid) begin
          ld_en    = 1'b1;
          state_nx = DONE;
        end else if (tmo_hit) begin
          bus_err_exc = 1'b1;
          state_nx    = DRAIN;
        end
      end
      DONE: state_nx = IDLE;
      DRAIN: begin
        mem_stall = aligned_acc;
        if (dresp_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised and directed bench for mem_stage_lsu against a transaction-level model.
module tb_mem_stage_lsu;

  localparam int unsigned TMO = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemWriteM, lbuM, lhuM, ErrorFlush;
  logic [1:0]  MemtoRegM, Sh_bM;
  logic [31:0] aluoutM, writedataM, dresp_rdata;
  logic        dreq_ready, dresp_valid;
  logic        dreq_valid, dreq_we, mem_stall, misalign_exc, bus_err_exc;
  logic [31:0] dreq_addr, dreq_wdata, load_dataM;
  logic [3:0]  dreq_be;

  mem_stage_lsu #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .Sh_bM(Sh_bM),
    .lbuM(lbuM), .lhuM(lhuM), .aluoutM(aluoutM), .writedataM(writedataM), .ErrorFlush(ErrorFlush),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we), .dreq_addr(dreq_addr),
    .dreq_be(dreq_be), .dreq_wdata(dreq_wdata), .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
    .mem_stall(mem_stall), .load_dataM(load_dataM), .misalign_exc(misalign_exc),
    .bus_err_exc(bus_err_exc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: what the bus/pipeline currently owes, not how the RTL sequences it.
  bit          m_busreq, m_owed, m_drain, m_done;
  int          m_age;
  bit          m_we;
  logic [31:0] m_addr, m_wd, m_load;
  logic [3:0]  m_be;
  int          m_off, m_nb;
  bit          m_zext;
  bit          last_stall;

  // Sampled DUT outputs of the most recent step.
  logic        s_valid, s_stall, s_mis, s_berr;
  logic [31:0] s_addr, s_load, s_wdata;
  logic [3:0]  s_be;

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] rd, input int off, input int nb,
                                          input bit zext);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < nb; k++) v = v | (((rd >> (8 * (off + k))) & 32'hFF) << (8 * k));
    if (nb < 4 && !zext && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  // One clock: compare DUT against the model at the falling edge, then advance the model.
  task automatic step();
    int          nb, off;
    bit          acc, mis, e_valid, e_stall, e_mis, e_berr;
    logic [31:0] n_load, lwd;
    logic [3:0]  lbe;
    @(negedge clk);
    e_valid = 0; e_stall = 0; e_mis = 0; e_berr = 0;
    nb  = nbytes_of(Sh_bM);
    off = int'(aluoutM[1:0]);
    acc = (MemWriteM || MemtoRegM == 2'b01) && !ErrorFlush;
    mis = (off % nb) != 0;
    lbe = 4'b0000;
    lwd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      lbe[i] = (i >= off) && (i < off + nb);
      lwd    = lwd | (((writedataM >> (8 * (i % nb))) & 32'hFF) << (8 * i));
    end
    if (!rst_n) begin
      m_busreq = 0; m_owed = 0; m_drain = 0; m_done = 0; m_load = 32'h0;
    end
    n_load = m_load;
    if (!rst_n) begin
    end else if (m_done) begin
      m_done = 0;
    end else if (m_drain) begin
      e_stall = acc && !mis;
      if (dresp_valid) m_drain = 0;
    end else if (m_owed) begin
      e_stall = acc && !mis;
      if (ErrorFlush) begin
        m_owed = 0; m_drain = !dresp_valid;
      end else if (dresp_valid) begin
        n_load = extract(dresp_rdata, m_off, m_nb, m_zext);
        m_owed = 0; m_done = 1;
      end else if (m_age == TMO - 1) begin
        e_berr = 1; m_owed = 0; m_drain = 1;
      end else m_age++;
    end else if (m_busreq) begin
      if (ErrorFlush) m_busreq = 0;
      else begin
        e_valid = 1; e_stall = acc && !mis;
        if (dreq_ready) begin
          m_busreq = 0;
          if (m_we) m_done = 1; else begin m_owed = 1; m_age = 0; end
        end else if (m_age == TMO - 1) begin
          e_berr = 1; m_busreq = 0;
        end else m_age++;
      end
    end else begin
      e_mis = acc && mis;
      if (acc && !mis) begin
        e_valid = 1; e_stall = 1;
        m_we = MemWriteM; m_addr = {aluoutM[31:2], 2'b00}; m_be = lbe; m_wd = lwd;
        m_off = off; m_nb = nb; m_zext = (nb == 1) ? lbuM : lhuM;
        if (dreq_ready) begin
          if (m_we) m_done = 1; else begin m_owed = 1; m_age = 0; end
        end else begin
          m_busreq = 1; m_age = 0;
        end
      end
    end
    s_valid = dreq_valid; s_stall = mem_stall; s_mis = misalign_exc; s_berr = bus_err_exc;
    s_addr = dreq_addr; s_be = dreq_be; s_wdata = dreq_wdata; s_load = load_dataM;
    check_eq("dreq_valid", s_valid, e_valid);
    check_eq("mem_stall", s_stall, e_stall);
    check_eq("misalign_exc", s_mis, e_mis);
    check_eq("bus_err_exc", s_berr, e_berr);
    check_eq("load_dataM", s_load, m_load);
    if (e_valid) begin
      check_eq("dreq_addr", s_addr, m_addr);
      check_eq("dreq_be", s_be, m_be);
      check_eq("dreq_we", dreq_we, m_we);
      if (m_we) check_eq("dreq_wdata", s_wdata, m_wd);
    end
    m_load     = n_load;
    last_stall = e_stall;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input bit we, input logic [1:0] mtr, input logic [1:0] sz, input bit lbu,
                           input bit lhu, input logic [31:0] addr, input logic [31:0] wd);
    MemWriteM = we; MemtoRegM = mtr; Sh_bM = sz; lbuM = lbu; lhuM = lhu;
    aluoutM = addr; writedataM = wd;
  endtask

  task automatic set_bubble();
    set_instr(0, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    int berr_at;
    rst_n = 1'b0; ErrorFlush = 0; dreq_ready = 0; dresp_valid = 0; dresp_rdata = 32'h0;
    set_instr(0, 2'b01, 2'b00, 0, 0, 32'h0000_0040, 32'h0);
    @(posedge clk); #1;
    step();
    check_eq("reset_valid", s_valid, 1'b0);
    check_eq("reset_load", s_load, 32'h0);
    rst_n = 1'b1;
    set_bubble();
    step();

    // 1: byte store to lane 3, accepted at once
    set_instr(1, 2'b00, 2'b10, 0, 0, 32'h0000_1003, 32'h0000_00AB);
    dreq_ready = 1;
    step();
    check_eq("t1_be", s_be, 4'b1000);
    check_eq("t1_wdata", s_wdata, 32'hABAB_ABAB);
    check_eq("t1_stall", s_stall, 1'b1);
    step();
    check_eq("t1_done_stall", s_stall, 1'b0);
    set_bubble();
    step();

    // 2: signed then unsigned half load from upper half, 3-cycle response latency
    for (int u = 0; u < 2; u++) begin
      set_instr(0, 2'b01, 2'b01, 0, u[0], 32'h0000_2002, 32'h0);
      dreq_ready = 1;
      step();
      dreq_ready = 0;
      step();
      step();
      dresp_valid = 1; dresp_rdata = 32'h8001_5A5A;
      step();
      dresp_valid = 0;
      step();
      check_eq(u == 0 ? "t2_lh" : "t2_lhu", s_load, u == 0 ? 32'hFFFF_8001 : 32'h0000_8001);
      check_eq("t2_done_stall", s_stall, 1'b0);
      set_bubble();
      step();
    end

    // 3: misaligned word load
    set_instr(0, 2'b01, 2'b00, 0, 0, 32'h0000_3001, 32'h0);
    dreq_ready = 1;
    step();
    check_eq("t3_exc", s_mis, 1'b1);
    check_eq("t3_valid", s_valid, 1'b0);
    check_eq("t3_stall", s_stall, 1'b0);
    set_bubble();
    step();

    // 4: request held stable while ready is low for 5 cycles
    set_instr(0, 2'b01, 2'b00, 0, 0, 32'h0000_4000, 32'h0);
    dreq_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t4_valid", s_valid, 1'b1);
      check_eq("t4_addr", s_addr, 32'h0000_4000);
      check_eq("t4_be", s_be, 4'b1111);
      check_eq("t4_stall", s_stall, 1'b1);
    end
    dreq_ready = 1;
    step();
    dreq_ready = 0; dresp_valid = 1; dresp_rdata = 32'h1234_5678;
    step();
    dresp_valid = 0;
    step();
    check_eq("t4_load", s_load, 32'h1234_5678);
    set_bubble();
    step();

    // 5: flush while waiting, late response must be discarded
    set_instr(0, 2'b01, 2'b00, 0, 0, 32'h0000_5000, 32'h0);
    dreq_ready = 1;
    step();
    dreq_ready = 0; ErrorFlush = 1;
    step();
    check_eq("t5_flush_stall", s_stall, 1'b0);
    ErrorFlush = 0;
    set_bubble();
    step();
    dresp_valid = 1; dresp_rdata = 32'hDEAD_BEEF;
    step();
    dresp_valid = 0;
    step();
    check_eq("t5_load_kept", s_load, 32'h1234_5678);

    // 6: timeout with ready never asserted, then reset pulse while waiting
    set_instr(0, 2'b01, 2'b00, 0, 0, 32'h0000_6000, 32'h0);
    dreq_ready = 0;
    berr_at = -1;
    for (int i = 0; i <= int'(TMO) + 2; i++) begin
      step();
      if (s_berr) begin berr_at = i; break; end
    end
    check_eq("t6_berr_cycle", 32'(berr_at), 32'(TMO));
    set_bubble();
    step();
    check_eq("t6_idle_valid", s_valid, 1'b0);
    set_instr(0, 2'b01, 2'b00, 0, 0, 32'h0000_7000, 32'h0);
    dreq_ready = 1;
    step();
    rst_n = 0;
    step();
    check_eq("t6_rst_valid", s_valid, 1'b0);
    check_eq("t6_rst_stall", s_stall, 1'b0);
    check_eq("t6_rst_load", s_load, 32'h0);
    rst_n = 1;
    set_bubble();
    step();

    // Random traffic: new M-stage instruction only when the pipeline was not stalled.
    for (int n = 0; n < 2000; n++) begin
      if (!last_stall || ErrorFlush) begin
        if ($urandom_range(3) == 0) set_bubble();
        else set_instr(1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                       1'($urandom_range(1)), 1'($urandom_range(1)),
                       ($urandom_range(2) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                       $urandom);
      end
      ErrorFlush  = ($urandom_range(19) == 0);
      dreq_ready  = ($urandom_range(2) != 0);
      dresp_valid = ($urandom_range(2) == 0);
      dresp_rdata = $urandom;
      rst_n       = ($urandom_range(299) != 0);
      step();
      rst_n = 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
